// File: rtl/divided_counter_display_pkg.sv
// Shared constants and helpers for the divided counter display block:
// active-low 7-segment codes, the blank code used for leading-zero
// suppression, and the BCD count type with its advance function.
package divided_counter_display_pkg;

   // Active-low segment patterns, bit 7 = DP (always off), bits 6:0 = g..a
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Digit code the decoder renders as all segments off
   localparam logic [3:0] BLANK_CODE = 4'hF;

   // Largest value a BCD digit may hold
   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

   // Two-digit BCD count as held in the counter register
   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd_count_t;

   // Next BCD value: ones roll 9 -> 0 with carry, tens wrap after max_tens
   function automatic bcd_count_t bcd_advance(input bcd_count_t cur,
                                              input logic [3:0] max_tens);
      bcd_count_t nxt;
      nxt = cur;
      if (cur.ones >= BCD_MAX_DIGIT) begin
         nxt.ones = 4'd0;
         if (cur.tens >= max_tens) begin
            nxt.tens = 4'd0;
         end else begin
            nxt.tens = cur.tens + 4'd1;
         end
      end else begin
         nxt.ones = cur.ones + 4'd1;
      end
      return nxt;
   endfunction

   // Tens digit shown on the display: blanked when zero
   function automatic logic [3:0] tens_display_code(input logic [3:0] tens);
      return (tens == 4'd0) ? BLANK_CODE : tens;
   endfunction

endpackage

// File: rtl/divided_counter_display_if.sv
// Bundle of the divider control and display outputs of the block.
// There is no valid/ready handshake here: divide_by is a level that is
// sampled every clock_in cycle, and all outputs are continuously valid
// (registered divider/counter state, combinational segment decode).
interface divided_counter_display_if #(
   parameter int DIV_WIDTH = 32
) ();

   logic [DIV_WIDTH-1:0] divide_by;
   logic                 clock_out;
   logic                 tick;
   logic [3:0]           counter1;
   logic [3:0]           counter10;
   logic [7:0]           seg_ones;
   logic [7:0]           seg_tens;

   // Board-side view: supplies the ratio, observes the display
   modport master (
      output divide_by,
      input  clock_out,
      input  tick,
      input  counter1,
      input  counter10,
      input  seg_ones,
      input  seg_tens
   );

   // Block-side view
   modport slave (
      input  divide_by,
      output clock_out,
      output tick,
      output counter1,
      output counter10,
      output seg_ones,
      output seg_tens
   );

endinterface

// File: rtl/divided_counter_display_seg.sv
// Combinational 4-bit value to active-low 7-segment decoder.
// Values 10..15 are shown blank; the decimal point is always off.
module seven_seg_decode
   import divided_counter_display_pkg::*;
(
   input  logic [3:0] value_i,
   output logic [7:0] seg_o
);

   // Table lookup of the segment pattern for one digit
   always_comb begin
      seg_o = SEG_BLANK;
      case (value_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/divided_counter_display.sv
// Programmable clock divider feeding a two-digit BCD counter (00..MAX_TENS9)
// with active-low 7-segment outputs and leading-zero blanking on the tens.
// The divider compares with >= so a lowered ratio takes effect at once
// instead of waiting for the counter to wrap through its full width.
module divided_counter_display
   import divided_counter_display_pkg::*;
#(
   parameter int DIV_WIDTH = 32,
   parameter int MAX_TENS  = 5
) (
   input  logic                    clock_in,
   input  logic                    reset_n,
   divided_counter_display_if.slave bus
);

   localparam logic [3:0]           MAX_TENS_C = 4'(MAX_TENS);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);

   logic [DIV_WIDTH-1:0] divide_by;
   logic [DIV_WIDTH-1:0] div_limit;
   logic                 half_done;

   logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
   logic                 clock_out_q, clock_out_d;
   logic                 tick_q, tick_d;
   bcd_count_t           count_q, count_d;

   logic [3:0]           seg_tens_val;
   logic [7:0]           seg_ones_w;
   logic [7:0]           seg_tens_w;

   assign divide_by = bus.divide_by;

   // Last div_cnt value of a half-period; a ratio of 0 behaves as 1
   assign div_limit = (divide_by == '0) ? '0 : (divide_by - DIV_ONE);
   assign half_done = (div_cnt_q >= div_limit);

   // Divider next state: count, and on the last cycle clear and toggle;
   // tick marks the toggle that takes clock_out from 0 to 1
   always_comb begin
      div_cnt_d   = div_cnt_q + DIV_ONE;
      clock_out_d = clock_out_q;
      tick_d      = 1'b0;
      if (half_done) begin
         div_cnt_d   = '0;
         clock_out_d = ~clock_out_q;
         tick_d      = ~clock_out_q;
      end
   end

   // Divider state registers
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_q   <= '0;
         clock_out_q <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         clock_out_q <= clock_out_d;
         tick_q      <= tick_d;
      end
   end

   // BCD count advances on the edge after the one that raised tick
   always_comb begin
      count_d = count_q;
      if (tick_q) begin
         count_d = bcd_advance(count_q, MAX_TENS_C);
      end
   end

   // BCD count register
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign seg_tens_val = tens_display_code(count_q.tens);

   seven_seg_decode u_dec_ones (
      .value_i (count_q.ones),
      .seg_o   (seg_ones_w)
   );

   seven_seg_decode u_dec_tens (
      .value_i (seg_tens_val),
      .seg_o   (seg_tens_w)
   );

   assign bus.clock_out = clock_out_q;
   assign bus.tick      = tick_q;
   assign bus.counter1  = count_q.ones;
   assign bus.counter10 = count_q.tens;
   assign bus.seg_ones  = seg_ones_w;
   assign bus.seg_tens  = seg_tens_w;

   // Digits never leave their BCD ranges
   a_digit_range : assert property (@(posedge clock_in) disable iff (!reset_n)
      (count_q.ones <= BCD_MAX_DIGIT) && (count_q.tens <= MAX_TENS_C));

   // A tick can only be present while the divided clock is high
   a_tick_high : assert property (@(posedge clock_in) disable iff (!reset_n)
      tick_q |-> clock_out_q);

endmodule

// File: tb/tb_divided_counter_display.sv
// Bench for divided_counter_display. The reference model tracks the
// number of clock_in edges spent in the current half-period and the count
// as a plain integer 0..59; digits and segment codes are derived from it
// with division and a lookup table.
module tb_divided_counter_display;

   localparam int MAX_TENS = 5;
   localparam int MODULUS  = (MAX_TENS + 1) * 10;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   // Clock and reset
   always #5 clk = ~clk;

   divided_counter_display_if #(.DIV_WIDTH(32)) bus ();

   divided_counter_display #(
      .DIV_WIDTH (32),
      .MAX_TENS  (MAX_TENS)
   ) dut (
      .clock_in (clk),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   int   m_since;
   int   m_count;
   logic m_clk;
   logic m_tick;

   function automatic int eff_div();
      int unsigned d;
      d = bus.divide_by;
      return (d == 0) ? 1 : int'(d);
   endfunction

   function automatic logic [7:0] exp_ones_seg();
      return seg_tab[m_count % 10];
   endfunction

   function automatic logic [7:0] exp_tens_seg();
      return ((m_count / 10) == 0) ? 8'hFF : seg_tab[m_count / 10];
   endfunction

   task automatic model_reset();
      m_since = 0;
      m_count = 0;
      m_clk   = 1'b0;
      m_tick  = 1'b0;
   endtask

   // One rising edge of clock_in in the model
   task automatic model_edge();
      if (m_tick) m_count = (m_count + 1) % MODULUS;
      m_since = m_since + 1;
      if (m_since >= eff_div()) begin
         m_since = 0;
         m_tick  = ~m_clk;
         m_clk   = ~m_clk;
      end else begin
         m_tick = 1'b0;
      end
   endtask

   // Driver: advance one edge, leave the bench 1 time unit after it
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset(input int div);
      bus.divide_by = div;
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic run_to_count(input int target, input string tag);
      int budget;
      budget = 0;
      while (m_count != target && budget < 2000) begin
         step();
         budget++;
      end
      if (m_count != target) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: model count %0d, required %0d", tag, m_count, target);
      end
   endtask

   task automatic test_reset();
      bus.divide_by = 4;
      reset_n = 1'b0;
      model_reset();
      repeat (5) @(posedge clk);
      #1;
      n_checks++; if (bus.clock_out !== 1'b0) begin n_fail++; $display("FAIL reset_clock_out: got %b want 0", bus.clock_out); end
      n_checks++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", bus.tick); end
      n_checks++; if (bus.counter1 !== 4'd0) begin n_fail++; $display("FAIL reset_counter1: got %0d want 0", bus.counter1); end
      n_checks++; if (bus.counter10 !== 4'd0) begin n_fail++; $display("FAIL reset_counter10: got %0d want 0", bus.counter10); end
      n_checks++; if (bus.seg_ones !== 8'hC0) begin n_fail++; $display("FAIL reset_seg_ones: got %h want c0", bus.seg_ones); end
      n_checks++; if (bus.seg_tens !== 8'hFF) begin n_fail++; $display("FAIL reset_seg_tens: got %h want ff", bus.seg_tens); end
   endtask

   // divide_by = 4 straight out of reset: rise at edge 4, fall at edge 8
   task automatic test_divider_period();
      logic exp_t;
      reset_n = 1'b1;
      for (int e = 1; e <= 24; e++) begin
         step();
         exp_t = (e == 4) || (e == 12) || (e == 20);
         n_checks++; if (bus.tick !== exp_t) begin n_fail++; $display("FAIL period_tick edge %0d: got %b want %b", e, bus.tick, exp_t); end
         n_checks++; if (bus.clock_out !== m_clk) begin n_fail++; $display("FAIL period_clock_out edge %0d: got %b want %b", e, bus.clock_out, m_clk); end
         n_checks++; if (bus.counter1 !== 4'(m_count % 10)) begin n_fail++; $display("FAIL period_counter1 edge %0d: got %0d want %0d", e, bus.counter1, m_count % 10); end
         if (e == 4) begin
            n_checks++; if (bus.clock_out !== 1'b1) begin n_fail++; $display("FAIL period_rise edge 4: got %b want 1", bus.clock_out); end
         end
         if (e == 8) begin
            n_checks++; if (bus.clock_out !== 1'b0) begin n_fail++; $display("FAIL period_fall edge 8: got %b want 0", bus.clock_out); end
         end
         if (e == 5) begin
            n_checks++; if (bus.counter1 !== 4'd1) begin n_fail++; $display("FAIL period_first_count edge 5: got %0d want 1", bus.counter1); end
         end
      end
   endtask

   task automatic test_rollover();
      do_reset(1);
      run_to_count(59, "rollover_59");
      n_checks++; if (bus.counter10 !== 4'd5 || bus.counter1 !== 4'd9) begin n_fail++; $display("FAIL rollover_count59: got %0d%0d want 59", bus.counter10, bus.counter1); end
      n_checks++; if (bus.seg_tens !== 8'h92) begin n_fail++; $display("FAIL rollover_seg_tens59: got %h want 92", bus.seg_tens); end
      n_checks++; if (bus.seg_ones !== 8'h90) begin n_fail++; $display("FAIL rollover_seg_ones59: got %h want 90", bus.seg_ones); end
      run_to_count(0, "rollover_00");
      n_checks++; if (bus.counter10 !== 4'd0 || bus.counter1 !== 4'd0) begin n_fail++; $display("FAIL rollover_count00: got %0d%0d want 00", bus.counter10, bus.counter1); end
      n_checks++; if (bus.seg_tens !== 8'hFF) begin n_fail++; $display("FAIL rollover_seg_tens00: got %h want ff", bus.seg_tens); end
      n_checks++; if (bus.seg_ones !== 8'hC0) begin n_fail++; $display("FAIL rollover_seg_ones00: got %h want c0", bus.seg_ones); end
   endtask

   task automatic test_tens_carry();
      do_reset(3);
      run_to_count(9, "carry_09");
      n_checks++; if (bus.counter1 !== 4'd9 || bus.counter10 !== 4'd0) begin n_fail++; $display("FAIL carry_count09: got %0d%0d want 09", bus.counter10, bus.counter1); end
      n_checks++; if (bus.seg_tens !== 8'hFF) begin n_fail++; $display("FAIL carry_blank09: got %h want ff", bus.seg_tens); end
      run_to_count(10, "carry_10");
      n_checks++; if (bus.counter10 !== 4'd1) begin n_fail++; $display("FAIL carry_counter10: got %0d want 1", bus.counter10); end
      n_checks++; if (bus.counter1 !== 4'd0) begin n_fail++; $display("FAIL carry_counter1: got %0d want 0", bus.counter1); end
      n_checks++; if (bus.seg_tens !== 8'hF9) begin n_fail++; $display("FAIL carry_seg_tens: got %h want f9", bus.seg_tens); end
      n_checks++; if (bus.seg_ones !== 8'hC0) begin n_fail++; $display("FAIL carry_seg_ones: got %h want c0", bus.seg_ones); end
   endtask

   // divide_by 8 -> 2 while 5 edges into a half-period
   task automatic test_ratio_change();
      int   budget;
      logic prev;
      logic c0;
      logic exp_c;
      do_reset(8);
      budget = 0;
      while (m_since != 5 && budget < 40) begin
         step();
         budget++;
      end
      prev = bus.clock_out;
      bus.divide_by = 2;
      step();
      n_checks++; if (bus.clock_out !== ~prev) begin n_fail++; $display("FAIL ratio_immediate_toggle: got %b want %b", bus.clock_out, ~prev); end
      c0 = ~prev;
      for (int i = 1; i <= 8; i++) begin
         step();
         exp_c = c0 ^ 1'((i / 2) % 2);
         n_checks++; if (bus.clock_out !== exp_c) begin n_fail++; $display("FAIL ratio_half_period edge %0d: got %b want %b", i, bus.clock_out, exp_c); end
      end
   endtask

   task automatic test_async_reset();
      do_reset(1);
      run_to_count(37, "async_37");
      n_checks++; if (bus.counter10 !== 4'd3 || bus.counter1 !== 4'd7) begin n_fail++; $display("FAIL async_pre_count: got %0d%0d want 37", bus.counter10, bus.counter1); end
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      n_checks++; if (bus.clock_out !== 1'b0 || bus.tick !== 1'b0) begin n_fail++; $display("FAIL async_divider: got clk %b tick %b want 0 0", bus.clock_out, bus.tick); end
      n_checks++; if (bus.counter1 !== 4'd0 || bus.counter10 !== 4'd0) begin n_fail++; $display("FAIL async_count: got %0d%0d want 00", bus.counter10, bus.counter1); end
      n_checks++; if (bus.seg_ones !== 8'hC0 || bus.seg_tens !== 8'hFF) begin n_fail++; $display("FAIL async_segs: got %h %h want ff c0", bus.seg_tens, bus.seg_ones); end
      #1;
      reset_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         n_checks++; if (bus.clock_out !== m_clk) begin n_fail++; $display("FAIL async_restart_clk edge %0d: got %b want %b", e, bus.clock_out, m_clk); end
         n_checks++; if (bus.counter1 !== 4'(m_count % 10) || bus.counter10 !== 4'(m_count / 10)) begin n_fail++; $display("FAIL async_restart_count edge %0d: got %0d%0d want %0d", e, bus.counter10, bus.counter1, m_count); end
      end
   endtask

   // Random ratios (including 0) changed at random points mid-period
   task automatic test_random();
      do_reset($urandom_range(0, 5));
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 15) == 0) bus.divide_by = $urandom_range(0, 6);
         step();
         n_checks++; if (bus.clock_out !== m_clk) begin n_fail++; $display("FAIL rand_clock_out cycle %0d: got %b want %b", c, bus.clock_out, m_clk); end
         n_checks++; if (bus.tick !== m_tick) begin n_fail++; $display("FAIL rand_tick cycle %0d: got %b want %b", c, bus.tick, m_tick); end
         n_checks++; if (bus.counter1 !== 4'(m_count % 10)) begin n_fail++; $display("FAIL rand_counter1 cycle %0d: got %0d want %0d", c, bus.counter1, m_count % 10); end
         n_checks++; if (bus.counter10 !== 4'(m_count / 10)) begin n_fail++; $display("FAIL rand_counter10 cycle %0d: got %0d want %0d", c, bus.counter10, m_count / 10); end
         n_checks++; if (bus.seg_ones !== exp_ones_seg()) begin n_fail++; $display("FAIL rand_seg_ones cycle %0d: got %h want %h", c, bus.seg_ones, exp_ones_seg()); end
         n_checks++; if (bus.seg_tens !== exp_tens_seg()) begin n_fail++; $display("FAIL rand_seg_tens cycle %0d: got %h want %h", c, bus.seg_tens, exp_tens_seg()); end
      end
   endtask

   initial begin
      bus.divide_by = 4;
      model_reset();
      test_reset();
      test_divider_period();
      test_rollover();
      test_tens_carry();
      test_ratio_change();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/divided_counter_display.md
# divided_counter_display

Single-clock block that divides the board reference clock by a run-time programmable ratio and counts the resulting ticks as a two-digit BCD value, 00–59. It drives two active-low 7-segment digits. It sits between the board clock/keys and the HEX displays. Top level supplies `divide_by` and may use `clock_out` (e.g. an LED blinker).

## Interface
Parameters:
- `DIV_WIDTH`, default 32: width of `divide_by` and the internal divider counter.
- `MAX_TENS`, default 5: tens digit at which the count wraps. Wrap occurs after `MAX_TENS`9.

Ports:
- `clock_in` — in, 1: sole clock. All flops use the rising edge.
- `reset_n` — in, 1: asynchronous, active-low reset.
- `divide_by` — in, DIV_WIDTH: half-period of `clock_out`, in `clock_in` cycles. Sampled every cycle; 0 is treated as 1.
- `clock_out` — out, 1: registered divided clock, period 2×`divide_by`.
- `tick` — out, 1: one-cycle pulse in the cycle `clock_out` goes 0→1.
- `counter1` — out, 4: BCD ones digit, 0–9.
- `counter10` — out, 4: BCD tens digit, 0–`MAX_TENS`.
- `seg_ones` — out, 8: active-low segments for `counter1`. Bit 7 = DP, bits 6:0 = g..a.
- `seg_tens` — out, 8: active-low segments for the displayed tens digit.

## Operation
- Divider: `div_cnt` increments every cycle. When `div_cnt >= divide_by-1`, `div_cnt` clears and `clock_out` toggles. Using `>=` means a lowered `divide_by` takes effect at once, with no long wrap.
- `tick` = 1 exactly when `clock_out` toggles from 0 to 1.
- Counter: on a cycle with `tick`=1, the BCD count advances.
  - `counter1` 9 → 0 with carry into `counter10`.
  - `MAX_TENS`9 → 00.
- Displayed tens code (`seg_tens_val`): 4'hF (blank) when `counter10`==0 (leading-zero blanking); otherwise `counter10`.
- Decoder (combinational, DP always off = 1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Values 10–15 = FF (blank).

## Timing
- Reset values while `reset_n`=0:
  - `div_cnt`=0, `clock_out`=0, `tick`=0, `counter1`=0, `counter10`=0.
  - `seg_ones`=C0, `seg_tens`=FF.
- Reset asserts asynchronously. Deassertion is used as is; no synchronizer inside the block.
- After reset release with constant `divide_by`=N: `clock_out` rises at the N-th rising edge, falls at the 2N-th, and so on.
- `tick` is registered. It is high in the same cycle `clock_out` first reads 1.
- Counter latency: `counter1` changes on the edge after the one that raised `tick`, i.e. at cycle N+1 for the first tick.
- Segment outputs follow the counter combinationally, with 0 extra cycles.
- Reset asserted mid-period: divider phase and count are lost; restart from the reset state.
- `divide_by` change mid-period:
  - New value ≥ current `div_cnt`+1: the current half-period extends to the new value.
  - Otherwise: toggle on the next edge.
- `divide_by`=1: `clock_out` toggles every cycle; `tick` every 2 cycles.

## Structure
- Shared package: the 10 segment constants, `SEG_BLANK`=8'hFF and `BLANK_CODE`=4'hF.
- Natural sub-modules:
  - `seven_seg_decode`: 4-bit value → 8-bit segments, combinational. Instantiated twice.
  - Optional `clock_div_core` holding the divider and tick logic.
- BCD counter lives inline in the top of this block.

## Test plan
- Reset:
  - Stimulus: hold `reset_n`=0 for 5 cycles, `divide_by`=4.
  - Required: `clock_out`=0, `tick`=0, counters 0, `seg_ones`=C0, `seg_tens`=FF.
- Divider period:
  - Stimulus: `divide_by`=4, release reset.
  - Required: `clock_out` rises at edge 4 and falls at edge 8. `tick` pulses at edges 4, 12, 20 only. `counter1`=1 after edge 5.
- Rollover:
  - Stimulus: `divide_by`=1, run 59 ticks.
  - Required: counter reads 59, `seg_tens`=92, `seg_ones`=90. Next tick gives 00, `seg_tens`=FF, `seg_ones`=C0.
- Tens carry:
  - Stimulus: count from 09 through one tick.
  - Required: `counter10`=1, `counter1`=0, `seg_tens`=F9, `seg_ones`=C0.
- Ratio change:
  - Stimulus: `divide_by`=8. At `div_cnt`=5, switch to 2.
  - Required: `clock_out` toggles on the next edge. Half-periods thereafter are 2 cycles.
- Async reset mid-count:
  - Stimulus: at count 37, pulse `reset_n` low between clock edges.
  - Required: all outputs reach reset values immediately, before the next edge, and the count restarts from 00.
